// File: rtl/dds_multichan.sv
// Time-multiplexed multi-channel DDS: per-channel phase accumulators, quarter-wave sine ROM, 3-stage pipeline.
// Define DDS_PHASE_DITHER_EN to add LFSR phase dither below the LUT address.
module dds_multichan #(
  parameter int G_NUM_CH         = 4,
  parameter int G_PHASE_WIDTH    = 24,
  parameter int G_LUT_ADDR_WIDTH = 10,
  parameter int G_DOUT_WIDTH     = 16,
  parameter int G_COMPLEX_OUTPUT = 0,
  localparam int CW = (G_NUM_CH > 1) ? $clog2(G_NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     enable,
  input  logic                     cfg_valid,
  input  logic [CW-1:0]            cfg_ch,
  input  logic [G_PHASE_WIDTH-1:0] cfg_ftw,
  input  logic [G_PHASE_WIDTH-1:0] cfg_poff,
  output logic [G_DOUT_WIDTH-1:0]  dout_re,
  output logic [G_DOUT_WIDTH-1:0]  dout_im,
  output logic [CW-1:0]            dout_ch,
  output logic                     dout_last,
  output logic                     dout_valid,
  input  logic                     dout_ready
);

  localparam int PW = G_PHASE_WIDTH;
  localparam int A  = G_LUT_ADDR_WIDTH;
  localparam int DW = G_DOUT_WIDTH;
  localparam int QW = A - 2;
  localparam int QN = 2 ** QW;
  localparam logic [DW-2:0] PEAK = {(DW-1){1'b1}};

  // Elaboration-time sine via Taylor series so the table needs no math library.
  function automatic logic [G_DOUT_WIDTH-2:0] rom_val(input int k);
    real x, term, s, amp;
    amp = 1.0;
    for (int i = 0; i < DW - 1; i++) amp = amp * 2.0;
    amp = amp - 1.0;
    x = 6.283185307179586 * real'(k);
    for (int i = 0; i < A; i++) x = x / 2.0;
    s    = x;
    term = x;
    for (int n = 1; n < 12; n++) begin
      term = -term * x * x / real'((2 * n) * (2 * n + 1));
      s    = s + term;
    end
    return (DW-1)'($rtoi(amp * s + 0.5));
  endfunction

  genvar gi;

  logic          stall;
  logic          issue;
  logic          cfg_hit;
  logic [CW-1:0] ch_cnt;
  logic [PW-1:0] phase_arr [G_NUM_CH];
  logic [DW-2:0] rom [QN];

  logic [A-1:0]    phase_top;
  logic [PW-A-1:0] phase_lo_unused;

  logic          s1_valid;
  logic [CW-1:0] s1_ch;
  logic [A-1:0]  s1_addr;

  logic          s2_valid;
  logic [CW-1:0] s2_ch;
  logic [DW-2:0] s2_mag_re;
  logic          s2_neg_re;

  logic [1:0]    quad_re;
  logic [QW-1:0] k_idx;
  logic [QW-1:0] k_mir;
  logic [DW-1:0] im_next;

  assign stall = dout_valid & ~dout_ready;
  assign issue = enable & ~stall;

  if (G_NUM_CH == (1 << CW)) begin : g_cfg_full
    assign cfg_hit = cfg_valid;
  end else begin : g_cfg_part
    assign cfg_hit = cfg_valid && (cfg_ch < CW'(G_NUM_CH));
  end

  for (gi = 0; gi < QN; gi++) begin : g_rom
    localparam logic [DW-2:0] ROM_VAL = rom_val(gi);
    assign rom[gi] = ROM_VAL;
  end

  // Per-channel state; cfg writes land regardless of enable/stall, issue reads old values.
  for (gi = 0; gi < G_NUM_CH; gi++) begin : g_ch
    logic [PW-1:0] acc;
    logic [PW-1:0] ftw;
    logic [PW-1:0] poff;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        acc  <= '0;
        ftw  <= '0;
        poff <= '0;
      end else begin
        if (cfg_hit && cfg_ch == CW'(gi)) begin
          ftw  <= cfg_ftw;
          poff <= cfg_poff;
        end
        if (!enable)
          acc <= '0;
        else if (issue && ch_cnt == CW'(gi))
          acc <= acc + ftw;
      end
    end

    assign phase_arr[gi] = acc + poff;
  end

`ifdef DDS_PHASE_DITHER_EN
  logic [15:0]   lfsr;
  logic [PW-1:0] dither;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      lfsr <= 16'hACE1;
    else if (!enable)
      lfsr <= 16'hACE1;
    else if (issue)
      lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
  end

  assign dither = PW'(lfsr[PW-A-1:0]);
  assign {phase_top, phase_lo_unused} = phase_arr[ch_cnt] + dither;
`else
  assign {phase_top, phase_lo_unused} = phase_arr[ch_cnt];
`endif

  // Quadrant fold: odd quadrants mirror the index, k=0 there is the peak not stored in the ROM.
  assign quad_re = s1_addr[A-1 -: 2];
  assign k_idx   = s1_addr[QW-1:0];
  assign k_mir   = QW'(0) - k_idx;

  if (G_COMPLEX_OUTPUT != 0) begin : g_im
    logic [1:0]    quad_im;
    logic [DW-2:0] mag_im;
    logic          neg_im;

    assign quad_im = quad_re + 2'd1;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        mag_im <= '0;
        neg_im <= 1'b0;
      end else if (enable && !stall) begin
        mag_im <= (quad_im[0] && k_idx == '0) ? PEAK : rom[quad_im[0] ? k_mir : k_idx];
        neg_im <= quad_im[1];
      end
    end

    assign im_next = neg_im ? -{1'b0, mag_im} : {1'b0, mag_im};
  end else begin : g_no_im
    assign im_next = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ch_cnt     <= '0;
      s1_valid   <= 1'b0;
      s1_ch      <= '0;
      s1_addr    <= '0;
      s2_valid   <= 1'b0;
      s2_ch      <= '0;
      s2_mag_re  <= '0;
      s2_neg_re  <= 1'b0;
      dout_re    <= '0;
      dout_im    <= '0;
      dout_ch    <= '0;
      dout_last  <= 1'b0;
      dout_valid <= 1'b0;
    end else if (!enable) begin
      ch_cnt     <= '0;
      s1_valid   <= 1'b0;
      s2_valid   <= 1'b0;
      dout_valid <= 1'b0;
    end else if (!stall) begin
      ch_cnt     <= (ch_cnt == CW'(G_NUM_CH - 1)) ? '0 : ch_cnt + 1'b1;
      s1_valid   <= 1'b1;
      s1_ch      <= ch_cnt;
      s1_addr    <= phase_top;
      s2_valid   <= s1_valid;
      s2_ch      <= s1_ch;
      s2_mag_re  <= (quad_re[0] && k_idx == '0) ? PEAK : rom[quad_re[0] ? k_mir : k_idx];
      s2_neg_re  <= quad_re[1];
      dout_re    <= s2_neg_re ? -{1'b0, s2_mag_re} : {1'b0, s2_mag_re};
      dout_im    <= im_next;
      dout_ch    <= s2_ch;
      dout_last  <= (s2_ch == CW'(G_NUM_CH - 1));
      dout_valid <= s2_valid;
    end
  end

endmodule

// File: tb/tb_dds_multichan.sv
// Scoreboard bench for dds_multichan: reference model pushes expected samples on issue, monitor pops on output.
module tb_dds_multichan;

  localparam int NCH = 4;

  logic        clk        = 1'b0;
  logic        reset_n    = 1'b0;
  logic        enable     = 1'b0;
  logic        cfg_valid  = 1'b0;
  logic [1:0]  cfg_ch     = '0;
  logic [23:0] cfg_ftw    = '0;
  logic [23:0] cfg_poff   = '0;
  logic        dout_ready = 1'b1;
  logic [15:0] dout_re;
  logic [15:0] dout_im;
  logic [1:0]  dout_ch;
  logic        dout_last;
  logic        dout_valid;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic [15:0] re;
    logic [15:0] im;
    logic [1:0]  ch;
    logic        last;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        head;
  exp_t        nx;
  logic [31:0] log1[$];
  logic [31:0] log2[$];
  logic [23:0] m_acc  [NCH];
  logic [23:0] m_ftw  [NCH];
  logic [23:0] m_poff [NCH];
  logic [23:0] m_phase;
  int          m_ch;
  int          m_addr;
  logic [15:0] re_pat [4];
  logic [15:0] im_pat [4];

  dds_multichan #(
    .G_NUM_CH        (4),
    .G_PHASE_WIDTH   (24),
    .G_LUT_ADDR_WIDTH(10),
    .G_DOUT_WIDTH    (16),
    .G_COMPLEX_OUTPUT(1)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .enable    (enable),
    .cfg_valid (cfg_valid),
    .cfg_ch    (cfg_ch),
    .cfg_ftw   (cfg_ftw),
    .cfg_poff  (cfg_poff),
    .dout_re   (dout_re),
    .dout_im   (dout_im),
    .dout_ch   (dout_ch),
    .dout_last (dout_last),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic int sin_ref(input int a);
    real v;
    v = 32767.0 * $sin(6.283185307179586 * real'(a) / 1024.0);
    if (v >= 0.0) return $rtoi(v + 0.5);
    return -$rtoi(0.5 - v);
  endfunction

  task automatic model_clear(input bit keep_cfg);
    for (int i = 0; i < NCH; i++) begin
      m_acc[i] = '0;
      if (!keep_cfg) begin
        m_ftw[i]  = '0;
        m_poff[i] = '0;
      end
    end
    m_ch = 0;
  endtask

  // Output side first (compare head, pop on accept), then model the issue for the coming edge.
  always @(negedge clk) begin
    if (reset_n) begin
      if (dout_valid) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $error("FAIL sb_underflow observed=valid expected=no_output");
        end else begin
          head = exp_q[0];
          check("sb_re", 32'(dout_re), 32'(head.re));
          check("sb_im", 32'(dout_im), 32'(head.im));
          check("sb_ch", 32'(dout_ch), 32'(head.ch));
          check("sb_last", 32'(dout_last), 32'(head.last));
          if (dout_ready) begin
            void'(exp_q.pop_front());
            $display("sample ch=%0d re=%0d im=%0d last=%0d", dout_ch,
                     $signed(dout_re), $signed(dout_im), dout_last);
            if (dout_ch == 2'd1) log1.push_back({dout_re, dout_im});
            if (dout_ch == 2'd2) log2.push_back({dout_re, dout_im});
          end
        end
      end
      if (!enable) begin
        exp_q.delete();
        log1.delete();
        log2.delete();
        model_clear(1'b1);
      end else if (!(dout_valid && !dout_ready)) begin
        m_phase       = m_acc[m_ch] + m_poff[m_ch];
        m_acc[m_ch]   = m_acc[m_ch] + m_ftw[m_ch];
        m_addr        = int'(m_phase[23:14]);
        nx.re         = 16'(sin_ref(m_addr));
        nx.im         = 16'(sin_ref((m_addr + 256) % 1024));
        nx.ch         = 2'(m_ch);
        nx.last       = (m_ch == NCH - 1);
        exp_q.push_back(nx);
        m_ch = (m_ch + 1) % NCH;
      end
      if (cfg_valid && int'(cfg_ch) < NCH) begin
        m_ftw[cfg_ch]  = cfg_ftw;
        m_poff[cfg_ch] = cfg_poff;
      end
    end
  end

  always @(negedge reset_n) begin
    exp_q.delete();
    log1.delete();
    log2.delete();
    model_clear(1'b0);
  end

  task automatic wait_logs(input int n1, input int n2);
    int n;
    n = 0;
    while ((log1.size() < n1 || log2.size() < n2) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("wait_logs", 32'(log1.size() >= n1 && log2.size() >= n2), 32'd1);
  endtask

  initial begin
    re_pat = '{16'h0000, 16'h7FFF, 16'h0000, 16'h8001};
    im_pat = '{16'h7FFF, 16'h0000, 16'h8001, 16'h0000};
    model_clear(1'b0);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(dout_valid), 32'd0);
    check("rst_re", 32'(dout_re), 32'd0);
    check("rst_im", 32'(dout_im), 32'd0);
    check("rst_ch", 32'(dout_ch), 32'd0);
    check("rst_last", 32'(dout_last), 32'd0);
    reset_n = 1'b1;

    // All cfg zero: latency 3, every channel re=0 im=peak, round-robin with last on ch3
    @(posedge clk); #1; enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i < 3) begin
        check("lat_valid", 32'(dout_valid), 32'd0);
      end else begin
        check("run_valid", 32'(dout_valid), 32'd1);
        check("run_ch", 32'(dout_ch), 32'((i - 3) % 4));
        check("run_last", 32'(dout_last), 32'((i - 3) % 4 == 3));
        check("run_re", 32'(dout_re), 32'h0000);
        check("run_im", 32'(dout_im), 32'h7FFF);
      end
    end

    // One disabled cycle with ch1 tuning write, then restart and a 10-cycle stall
    @(posedge clk); #1;
    enable = 1'b0; cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_ftw = 24'h400000; cfg_poff = 24'h0;
    @(posedge clk); #1;
    cfg_valid = 1'b0; enable = 1'b1;
    @(negedge clk);
    check("dis_valid", 32'(dout_valid), 32'd0);
    for (int j = 1; j < 4; j++) begin
      @(negedge clk);
      check("restart_lat", 32'(dout_valid), 32'(j == 3));
    end
    check("restart_ch", 32'(dout_ch), 32'd0);
    repeat (6) @(posedge clk);
    #1; dout_ready = 1'b0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      check("stall_valid", 32'(dout_valid), 32'd1);
    end
    @(posedge clk); #1; dout_ready = 1'b1;
    wait_logs(9, 0);
    for (int i = 0; i < 9 && i < log1.size(); i++) begin
      check("ch1_re", 32'(log1[i][31:16]), 32'(re_pat[i % 4]));
      check("ch1_im", 32'(log1[i][15:0]), 32'(im_pat[i % 4]));
    end

    // ch2 quarter-turn phase offset with zero tuning word
    @(posedge clk); #1;
    enable = 1'b0; cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_ftw = 24'h0; cfg_poff = 24'h400000;
    @(posedge clk); #1;
    cfg_valid = 1'b0; enable = 1'b1;
    wait_logs(4, 4);
    for (int i = 0; i < 4 && i < log2.size(); i++) begin
      check("ch2_re", 32'(log2[i][31:16]), 32'h7FFF);
      check("ch2_im", 32'(log2[i][15:0]), 32'h0000);
    end

    // Asynchronous reset pulse mid-stream, away from any clock edge
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    check("arst_valid", 32'(dout_valid), 32'd0);
    check("arst_re", 32'(dout_re), 32'd0);
    check("arst_im", 32'(dout_im), 32'd0);
    check("arst_ch", 32'(dout_ch), 32'd0);
    check("arst_last", 32'(dout_last), 32'd0);
    #1;
    reset_n = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      check("arst_lat", 32'(dout_valid), 32'(j == 3));
    end
    check("arst_first_ch", 32'(dout_ch), 32'd0);
    wait_logs(2, 2);
    for (int i = 0; i < 2 && i < log1.size() && i < log2.size(); i++) begin
      check("arst_ch1_re", 32'(log1[i][31:16]), 32'h0000);
      check("arst_ch2_re", 32'(log2[i][31:16]), 32'h0000);
      check("arst_ch2_im", 32'(log2[i][15:0]), 32'h7FFF);
    end

    repeat (4) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
